// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with TX FIFO, sitting
//               between the processor dmem port and the dmem syncram.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [11:0] TX_ADDR      = 12'hFFE,
   parameter logic [11:0] STATUS_ADDR  = 12'hFFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic [31:0] q_dmem,
   output logic        mem_wren,
   output logic [31:0] q_proc,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic [7:0]  fifo_count
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam int c_tmr_w = $clog2(CLKS_PER_BIT);

   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]         r_fifo_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_overflow;

   state_t             r_state;
   logic [c_tmr_w-1:0] r_timer;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;

   logic               r_status_sel;
   logic [31:0]        r_status;

   logic               w_tx_sel;
   logic               w_status_sel;
   logic               w_push_req;
   logic               w_push_ok;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_bit_end;
   logic [31:0]        w_status;
   logic               w_unused;

   assign w_tx_sel     = (address_dmem == TX_ADDR);
   assign w_status_sel = (address_dmem == STATUS_ADDR);
   assign mem_wren     = wren & ~w_tx_sel & ~w_status_sel;

   assign w_full     = (r_count == c_depth);
   assign w_empty    = (r_count == '0);
   assign w_pop      = (r_state == S_IDLE) & ~w_empty;
   assign w_push_req = wren & w_tx_sel;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push_ok  = w_push_req & (~w_full | w_pop);
   assign w_bit_end  = (r_timer == c_tmr_last);

   assign tx_busy    = (r_state != S_IDLE);
   assign uart_tx    = r_tx;
   assign fifo_count = 8'(r_count);

   assign w_status = {16'h0000, fifo_count, 4'h0, r_overflow, tx_busy, w_empty, w_full};
   assign q_proc   = r_status_sel ? r_status : q_dmem;

   assign w_unused = ^data[31:8];

   // Storage array carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (w_push_ok) begin
         r_fifo_mem[r_wr_ptr] <= data[7:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_status_sel <= 1'b0;
         r_status     <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         if (w_push_ok && !w_pop) begin
            r_count <= r_count + c_cnt_w'(1);
         end else if (!w_push_ok && w_pop) begin
            r_count <= r_count - c_cnt_w'(1);
         end
         if (w_push_req && !w_push_ok) begin
            r_overflow <= 1'b1;
         end else if (wren && w_status_sel) begin
            r_overflow <= 1'b0;
         end
         r_status_sel <= w_status_sel & ~wren;
         r_status     <= w_status;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_timer <= '0;
               r_tx    <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_fifo_mem[r_rd_ptr];
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_timer   <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_timer <= r_timer + c_tmr_w'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_timer <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer + c_tmr_w'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_timer <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer + c_tmr_w'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
